// File: rtl/credit_change_ctrl_pkg.sv
// Shared types and constants for the vending-machine credit/change controller.
package credit_pkg;
  localparam int W_DEF          = 8;
  localparam int MAX_CREDIT_DEF = 20;
  localparam int COIN_100_VAL   = 1;
  localparam int COIN_500_VAL   = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PAY  = 3'd1,
    GAP  = 3'd2
  } state_t;
endpackage

// File: rtl/credit_change_ctrl_if.sv
// Coin/purchase/dispense bundle between the coin acceptor, drink FSM and change controller.
interface credit_change_ctrl_if #(
  parameter int W = 8
);
  logic         coin_100;
  logic         coin_500;
  logic         buy;
  logic [W-1:0] price;
  logic         refund;
  logic [W-1:0] credit;
  logic         sufficient;
  logic         accept;
  logic         deny;
  logic         coin_reject;
  logic         out_100;
  logic         out_500;
  logic         busy;
  logic [2:0]   state_dbg;

  modport master (
    output coin_100, coin_500, buy, price, refund,
    input  credit, sufficient, accept, deny, coin_reject, out_100, out_500, busy, state_dbg
  );

  modport slave (
    input  coin_100, coin_500, buy, price, refund,
    output credit, sufficient, accept, deny, coin_reject, out_100, out_500, busy, state_dbg
  );
endinterface

// File: rtl/credit_change_ctrl_dispense_timer.sv
// Loadable down-counter timing the dispense pulse (PAY) and inter-coin gap (GAP).
module dispense_timer #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_sel_gap,
  output logic o_expired
);
  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [TW-1:0] r_count;

  // Loading N-1 makes the expiry flag fall on the Nth cycle of the interval.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_sel_gap ? TW'(GAP_CYC - 1) : TW'(PULSE_CYC - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_expired = (r_count == '0);
endmodule

// File: rtl/credit_change_ctrl.sv
// Credit accumulation, purchase/refund arbitration and one-coin-at-a-time change payout.
// Optional greedy 500-coin change is enabled by defining CHANGE_500_EN.
module credit_change_ctrl
  import credit_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  credit_change_ctrl_if.slave  bus
);
  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_credit, w_credit_nxt;
  logic         r_accept, r_deny, r_coin_reject;
  logic         w_accept_nxt, w_deny_nxt, w_reject_nxt;
  logic         w_tmr_load, w_tmr_sel_gap, w_tmr_expired;
  logic         w_coin_any, w_taken, w_sel_500;
  logic [W:0]   w_add, w_sum;
  logic [W-1:0] w_pay_val;

  dispense_timer #(
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_sel_gap (w_tmr_sel_gap),
    .o_expired (w_tmr_expired)
  );

  // One extra bit so an over-limit sum is detected instead of wrapping.
  assign w_coin_any = bus.coin_100 | bus.coin_500;
  assign w_add      = (bus.coin_500 ? (W+1)'(COIN_500_VAL) : '0)
                    + (bus.coin_100 ? (W+1)'(COIN_100_VAL) : '0);
  assign w_sum      = {1'b0, r_credit} + w_add;

`ifdef CHANGE_500_EN
  assign w_sel_500   = (r_credit >= W'(COIN_500_VAL));
  assign bus.out_500 = (r_state == PAY) & w_sel_500;
`else
  assign w_sel_500   = 1'b0;
  assign bus.out_500 = 1'b0;
`endif
  assign w_pay_val   = w_sel_500 ? W'(COIN_500_VAL) : W'(COIN_100_VAL);
  assign bus.out_100 = (r_state == PAY) & ~w_sel_500;

  assign bus.credit      = r_credit;
  assign bus.sufficient  = (r_credit >= bus.price);
  assign bus.accept      = r_accept;
  assign bus.deny        = r_deny;
  assign bus.coin_reject = r_coin_reject;
  assign bus.busy        = (r_state != IDLE);
  assign bus.state_dbg   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_accept      <= 1'b0;
      r_deny        <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_accept      <= w_accept_nxt;
      r_deny        <= w_deny_nxt;
      r_coin_reject <= w_reject_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_accept_nxt  = 1'b0;
    w_deny_nxt    = 1'b0;
    w_reject_nxt  = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_sel_gap = 1'b0;
    w_taken       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.refund) begin
          if (r_credit != '0) begin
            w_taken     = 1'b1;
            w_state_nxt = PAY;
            w_tmr_load  = 1'b1;
          end
        end else if (bus.buy) begin
          if (r_credit >= bus.price) begin
            w_taken      = 1'b1;
            w_accept_nxt = 1'b1;
            w_credit_nxt = r_credit - bus.price;
            if (r_credit != bus.price) begin
              w_state_nxt = PAY;
              w_tmr_load  = 1'b1;
            end
          end else begin
            w_deny_nxt = 1'b1;
          end
        end
        // Coins lose to an accepted refund/buy in the same cycle.
        if (w_coin_any) begin
          if (w_taken || (w_sum > (W+1)'(MAX_CREDIT))) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_credit_nxt = w_sum[W-1:0];
          end
        end
      end
      PAY: begin
        w_reject_nxt = w_coin_any;
        w_deny_nxt   = bus.buy;
        if (w_tmr_expired) begin
          w_credit_nxt  = r_credit - w_pay_val;
          w_state_nxt   = GAP;
          w_tmr_load    = 1'b1;
          w_tmr_sel_gap = 1'b1;
        end
      end
      GAP: begin
        w_reject_nxt = w_coin_any;
        w_deny_nxt   = bus.buy;
        if (w_tmr_expired) begin
          if (r_credit != '0) begin
            w_state_nxt = PAY;
            w_tmr_load  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_credit_change_ctrl.sv
// Scoreboard bench for credit_change_ctrl: transaction-level model predicts events and payout schedule.
module tb_credit_change_ctrl;
  import credit_pkg::*;

  localparam int W      = 8;
  localparam int MAXC   = 20;
  localparam int PULSE  = 4;
  localparam int GAPC   = 2;
  localparam int COIN_T = PULSE + GAPC;
  localparam int K_ACC  = 0;
  localparam int K_DENY = 1;
  localparam int K_REJ  = 2;
  localparam int K_COIN = 3;

  typedef struct {
    int value;
    int credit;  // -1: credit not predicted (event while paying out)
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  credit_change_ctrl_if #(.W(W)) bus ();

  credit_change_ctrl #(
    .W          (W),
    .MAX_CREDIT (MAXC),
    .PULSE_CYC  (PULSE),
    .GAP_CYC    (GAPC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[4][$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   idle_at  = 0;
  int   m_credit = 0;
  int   p_cur    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input int k, input int v, input int c);
    exp_t x;
    x.value  = v;
    x.credit = c;
    q[k].push_back(x);
  endtask

  function automatic int coin_val(input int rem);
`ifdef CHANGE_500_EN
    return (rem >= 5) ? 5 : 1;
`else
    return (rem >= 1) ? 1 : 1;
`endif
  endfunction

  // Change of 'amount' paid as a coin list; each coin occupies PULSE+GAP cycles.
  task automatic schedule_payout(input int e, input int amount);
    int rem;
    int n;
    int v;
    rem = amount;
    n   = 0;
    while (rem > 0) begin
      v = coin_val(rem);
      push(K_COIN, v, rem);
      rem -= v;
      n++;
    end
    idle_at = e + COIN_T * n;
  endtask

  // Drive one cycle of inputs and advance the model for the edge that samples them.
  task automatic step(input bit c1, input bit c5, input bit b, input int p, input bit r);
    int e, obs, add;
    bit taken, denied;
    @(negedge clk);
    bus.coin_100 = c1;
    bus.coin_500 = c5;
    bus.buy      = b;
    bus.price    = W'(p);
    bus.refund   = r;
    p_cur        = p;
    e      = cyc + 1;
    taken  = 0;
    denied = 0;
    obs    = m_credit;
    if (e <= idle_at) begin
      if (c1 || c5) push(K_REJ, 0, -1);
      if (b) push(K_DENY, 0, -1);
    end else begin
      if (r) begin
        if (m_credit > 0) begin
          taken = 1;
          schedule_payout(e, m_credit);
          m_credit = 0;
        end
      end else if (b) begin
        if (m_credit >= p) begin
          taken    = 1;
          obs      = m_credit - p;
          push(K_ACC, 0, obs);
          m_credit = 0;
          if (obs > 0) schedule_payout(e, obs);
        end else begin
          denied = 1;
        end
      end
      if (c1 || c5) begin
        add = (c5 ? 5 : 0) + (c1 ? 1 : 0);
        if (taken) push(K_REJ, 0, obs);
        else if (m_credit + add <= MAXC) m_credit += add;
        else push(K_REJ, 0, m_credit);
      end
      if (denied) push(K_DENY, 0, m_credit);
    end
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((cyc + 1 <= idle_at) && (n < 2000)) begin
      step(0, 0, 0, $urandom_range(0, 12), 0);
      n++;
    end
    if (n >= 2000) check("idle_wait_timeout", n, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic pop_cmp(input int k, input string name, input int val);
    exp_t x;
    if (q[k].size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event, got value %0d credit %0d required none", name, val, bus.credit);
    end else begin
      x = q[k].pop_front();
      check({name, "_value"}, val, x.value);
      if (x.credit >= 0) check({name, "_credit"}, int'(bus.credit), x.credit);
    end
  endtask

  // Monitor: compares DUT events against the scoreboard, independent of stimulus.
  bit prev_100 = 0;
  bit prev_500 = 0;
  int hi_len   = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("busy", int'(bus.busy), int'(cyc < idle_at));
      if (cyc >= idle_at) begin
        check("credit_idle", int'(bus.credit), m_credit);
        check("sufficient", int'(bus.sufficient), int'(m_credit >= p_cur));
      end
      if (bus.accept)      pop_cmp(K_ACC, "accept", 0);
      if (bus.deny)        pop_cmp(K_DENY, "deny", 0);
      if (bus.coin_reject) pop_cmp(K_REJ, "coin_reject", 0);
      if (bus.out_100 && !prev_100) pop_cmp(K_COIN, "coin_out", 1);
      if (bus.out_500 && !prev_500) pop_cmp(K_COIN, "coin_out", 5);
      if (bus.out_100 || bus.out_500) hi_len++;
      else if (hi_len != 0) begin
        check("pulse_len", hi_len, PULSE);
        hi_len = 0;
      end
      prev_100 = bus.out_100;
      prev_500 = bus.out_500;
    end else begin
      prev_100 = 0;
      prev_500 = 0;
      hi_len   = 0;
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.coin_100 = 1'b0;
    bus.coin_500 = 1'b0;
    bus.buy      = 1'b0;
    bus.refund   = 1'b0;
    bus.price    = W'(3);
    p_cur        = 3;
    repeat (2) @(negedge clk);
    #1;
    check("rst_credit", int'(bus.credit), 0);
    check("rst_accept", int'(bus.accept), 0);
    check("rst_deny", int'(bus.deny), 0);
    check("rst_reject", int'(bus.coin_reject), 0);
    check("rst_out_100", int'(bus.out_100), 0);
    check("rst_out_500", int'(bus.out_500), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_state", int'(bus.state_dbg), 0);
    check("rst_sufficient_p3", int'(bus.sufficient), 0);
    bus.price = '0;
    p_cur     = 0;
    #1;
    check("rst_sufficient_p0", int'(bus.sufficient), 1);
    @(negedge clk);
    idle_at  = cyc;
    m_credit = 0;
    rst_n    = 1'b1;

    // 5+1+1 = 7, buy 3 -> 4 coins of change
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    idle_wait();
    // credit 2: denied buy, then refund
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 0, 0, 1);
    idle_wait();
    // credit 18: single and double coin overflow, then clear with exact buy
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 18, 0);
    // exact-price buy never enters payout
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 0);
    // coin during a refund payout
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    idle_wait();
    // credit 12 refund (500 coins used when the feature is built in)
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle_wait();

    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           sel < 2, $urandom_range(0, 12), sel == 2);
    end
    idle_wait();

    // asynchronous reset in the middle of a payout (credit 4)
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_100", int'(bus.out_100), 0);
    check("async_rst_credit", int'(bus.credit), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_state", int'(bus.state_dbg), 0);
    q[K_COIN].delete();
    @(negedge clk);
    idle_at  = cyc;
    m_credit = 0;
    rst_n    = 1'b1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    check("left_accept", q[K_ACC].size(), 0);
    check("left_deny", q[K_DENY].size(), 0);
    check("left_reject", q[K_REJ].size(), 0);
    check("left_coin", q[K_COIN].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
